// File: rtl/rsa_mult_pkg.sv
// Shared constants for the wide RSA multiplier: limb width, core latency and FSM encodings.
package rsa_mult_pkg;

    localparam int LIMB_W   = 32;
    localparam int CORE_LAT = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MULT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/rsa_limb_mult32.sv
// 32x32 unsigned multiplier with registered inputs and registered output.
// Maps onto a single MULT36X36 (AREG=BREG=OUT0_REG=1, PIPE_REG=0).
module rsa_limb_mult32
    import rsa_mult_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [LIMB_W-1:0]   a,
    input  logic [LIMB_W-1:0]   b,
    output logic [2*LIMB_W-1:0] p
);

    logic [LIMB_W-1:0] a_r;
    logic [LIMB_W-1:0] b_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_r <= '0;
            b_r <= '0;
            p   <= '0;
        end else if (ce) begin
            a_r <= a;
            b_r <= b;
            p   <= (2*LIMB_W)'(a_r) * (2*LIMB_W)'(b_r);
        end
    end

endmodule

// File: rtl/rsa_wide_mult.sv
// Sequential WIDTH x WIDTH unsigned schoolbook multiplier over 32-bit limbs,
// one limb product per cycle, with valid/ready handshakes and a low-half-only mode.
module rsa_wide_mult
    import rsa_mult_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               low_only,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int LIMBS = WIDTH / LIMB_W;
    localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam int TAG_W = $clog2(2 * LIMBS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LIMBS - 1);
    localparam logic [2*WIDTH-1:0] LOW_MASK = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

    logic [1:0]                      state;
    logic [LIMBS-1:0][LIMB_W-1:0]    a_limbs;
    logic [LIMBS-1:0][LIMB_W-1:0]    b_limbs;
    logic                            low_q;
    logic [IDX_W-1:0]                i_idx;
    logic [IDX_W-1:0]                j_idx;
    logic [IDX_W-1:0]                j_last;
    logic                            last_pair;
    logic                            issue;
    logic [TAG_W-1:0]                issue_tag;
    logic [CORE_LAT-1:0]             vld_pipe;
    logic [TAG_W-1:0]                tag_pipe [CORE_LAT];
    logic [2*LIMB_W-1:0]             core_p;
    logic [2*WIDTH-1:0]              addend;
    logic [2*WIDTH-1:0]              acc;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    // In low-half mode the inner loop stops at i+j = LIMBS-1, so skipped pairs cost no cycles.
    assign j_last    = low_q ? (LAST_IDX - i_idx) : LAST_IDX;
    assign last_pair = (i_idx == LAST_IDX) && (j_idx == j_last);
    assign issue     = (state == S_MULT);
    assign issue_tag = TAG_W'(i_idx) + TAG_W'(j_idx);

    rsa_limb_mult32 u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (busy),
        .a       (a_limbs[i_idx]),
        .b       (b_limbs[j_idx]),
        .p       (core_p)
    );

    assign addend = (2*WIDTH)'(core_p) << {tag_pipe[CORE_LAT-1], 5'b0};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int k = 0; k < CORE_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[CORE_LAT-2:0], issue};
            tag_pipe[0] <= issue_tag;
            for (int k = 1; k < CORE_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            a_limbs <= '0;
            b_limbs <= '0;
            low_q   <= 1'b0;
            i_idx   <= '0;
            j_idx   <= '0;
            acc     <= '0;
            result  <= '0;
        end else begin
            if (vld_pipe[CORE_LAT-1]) acc <= acc + addend;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_limbs <= a;
                        b_limbs <= b;
                        low_q   <= low_only;
                        i_idx   <= '0;
                        j_idx   <= '0;
                        acc     <= '0;
                        state   <= S_MULT;
                    end
                end
                S_MULT: begin
                    if (last_pair) begin
                        state <= S_DRAIN;
                    end else if (j_idx == j_last) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The final accumulate has landed once the whole tag pipe reads empty.
                    if (vld_pipe == '0) begin
                        result <= low_q ? (acc & LOW_MASK) : acc;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
